// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Controller that hands a WIDTH-bit data mux over to IJTAG.
// The host writes a small TDR that holds a test-ownership request and the test data word.
// The block requests a hold from the functional logic and waits for the acknowledge.
// Settle delays are applied before and after the mux select changes.
// All state changes occur on the rising edge of ijtag_tck.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
    parameter int WIDTH   = 3,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic             func_hold_ack,
    output logic             func_hold_req,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             hold_error
);

    // The counter must hold the larger of the two reload values.
    // It is at least one bit wide so that degenerate parameters still elaborate.
    localparam int MAX_CNT = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FUNC,
        ST_HOLD,
        ST_SETTLE_IN,
        ST_TEST,
        ST_SETTLE_OUT
    } state_t;

    state_t            r_state;
    logic [WIDTH+1:0]  r_sr;
    logic              r_upd_req;
    logic [WIDTH-1:0]  r_upd_data;
    logic              r_hold_error;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_select;
    logic              r_hold_req;

    logic w_capture;
    logic w_shift;
    logic w_update;
    logic w_cnt_zero;
    logic w_err_set;
    logic w_err_clr;

    // TDR operations are mutually exclusive: capture beats shift, and shift beats update.
    assign w_capture  = ijtag_sel & ijtag_ce;
    assign w_shift    = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign w_update   = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
    assign w_cnt_zero = (r_cnt == '0);

    // The handshake is broken in three cases:
    //   - the hold times out;
    //   - the acknowledge drops while settling in;
    //   - the acknowledge drops while in TEST.
    assign w_err_set = ((r_state == ST_HOLD) & r_upd_req & ~func_hold_ack & w_cnt_zero) |
                       ((r_state == ST_SETTLE_IN) & ~func_hold_ack) |
                       ((r_state == ST_TEST) & ~func_hold_ack);
    assign w_err_clr = w_update & r_sr[WIDTH+1];

    assign ijtag_so       = r_sr[0];
    assign ijtag_data_out = r_upd_data;
    assign ijtag_select   = r_select;
    assign func_hold_req  = r_hold_req;
    assign hold_error     = r_hold_error;

    // Test data register: capture status, shift toward scan out, update the request and data.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_sr       <= '0;
            r_upd_req  <= 1'b0;
            r_upd_data <= '0;
        end else if (w_capture) begin
            r_sr <= {r_hold_error, (r_state == ST_TEST), r_upd_data};
        end else if (w_shift) begin
            r_sr <= {ijtag_si, r_sr[WIDTH+1:1]};
        end else if (w_update) begin
            r_upd_req  <= r_sr[WIDTH];
            r_upd_data <= r_sr[WIDTH-1:0];
        end
    end

    // Sticky handshake error flag; a new failure outranks a host clear in the same cycle.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_hold_error <= 1'b0;
        end else if (w_err_set) begin
            r_hold_error <= 1'b1;
        end else if (w_err_clr) begin
            r_hold_error <= 1'b0;
        end
    end

    // Ownership sequencer.
    // Select and hold_req are registered alongside the state, so they always decode the current state.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_state    <= ST_FUNC;
            r_cnt      <= '0;
            r_select   <= 1'b0;
            r_hold_req <= 1'b0;
        end else begin
            case (r_state)
                ST_FUNC: begin
                    if (r_upd_req) begin
                        r_state    <= ST_HOLD;
                        r_cnt      <= TIMEOUT_LOAD;
                        r_hold_req <= 1'b1;
                        r_select   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!r_upd_req) begin
                        r_state    <= ST_FUNC;
                        r_hold_req <= 1'b0;
                        r_select   <= 1'b0;
                    end else if (func_hold_ack) begin
                        r_state    <= ST_SETTLE_IN;
                        r_cnt      <= SETTLE_LOAD;
                        r_hold_req <= 1'b1;
                        r_select   <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state    <= ST_FUNC;
                        r_hold_req <= 1'b0;
                        r_select   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE_IN: begin
                    if (!func_hold_ack) begin
                        r_state    <= ST_FUNC;
                        r_hold_req <= 1'b0;
                        r_select   <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state    <= ST_TEST;
                        r_hold_req <= 1'b1;
                        r_select   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_TEST: begin
                    // A dropped acknowledge is reported through the error flag only.
                    // The block stays in TEST until the host releases it.
                    if (!r_upd_req) begin
                        r_state    <= ST_SETTLE_OUT;
                        r_cnt      <= SETTLE_LOAD;
                        r_hold_req <= 1'b1;
                        r_select   <= 1'b0;
                    end
                end
                ST_SETTLE_OUT: begin
                    // A new request is deliberately ignored until FUNC is reached.
                    if (w_cnt_zero) begin
                        r_state    <= ST_FUNC;
                        r_hold_req <= 1'b0;
                        r_select   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_FUNC;
                    r_hold_req <= 1'b0;
                    r_select   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed bench for the IJTAG data mux controller.
// The bench uses the default parameters: WIDTH=3, SETTLE=4, TIMEOUT=64.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       ce;
    logic       se;
    logic       ue;
    logic       si;
    logic       so;
    logic       ack;
    logic       hreq;
    logic       msel;
    logic [2:0] dout;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3),
        .SETTLE(4),
        .TIMEOUT(64)
    ) dut (
        .ijtag_tck     (clk),
        .ijtag_reset   (rst),
        .ijtag_sel     (sel),
        .ijtag_ce      (ce),
        .ijtag_se      (se),
        .ijtag_ue      (ue),
        .ijtag_si      (si),
        .ijtag_so      (so),
        .func_hold_ack (ack),
        .func_hold_req (hreq),
        .ijtag_select  (msel),
        .ijtag_data_out(dout),
        .hold_error    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       ce;
        logic       se;
        logic       ue;
        logic       si;
        logic       exp_so;
        logic [2:0] exp_dout;
        logic       exp_msel;
        logic       exp_hreq;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    // Outputs are sampled at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tdr();
        sel = 1'b0;
        ce  = 1'b0;
        se  = 1'b0;
        ue  = 1'b0;
        si  = 1'b0;
    endtask

    task automatic capture();
        sel = 1'b1;
        ce  = 1'b1;
        step();
        idle_tdr();
    endtask

    // Shifts val in, LSB first. Returns the prior register contents as seen on so.
    task automatic shift_word(input logic [4:0] val, output logic [4:0] got);
        for (int i = 0; i < 5; i++) begin
            sel    = 1'b1;
            se     = 1'b1;
            si     = val[i];
            got[i] = so;
            step();
        end
        idle_tdr();
    endtask

    task automatic update();
        sel = 1'b1;
        ue  = 1'b1;
        step();
        idle_tdr();
    endtask

    task automatic load(input logic [4:0] val);
        logic [4:0] dummy;
        shift_word(val, dummy);
        update();
    endtask

    initial begin
        logic [4:0] got;

        // Table of single-cycle TDR steps with the FSM held in FUNC (no request is loaded).
        //            sel  ce   se   ue   si   so   dout    msel hreq
        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,3'b000,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,3'b000,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,3'b000,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,3'b000,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,3'b000,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,3'b110,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,3'b110,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,3'b110,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,3'b110,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,3'b110,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,3'b110,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,3'b110,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,3'b110,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,3'b110,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,3'b011,1'b0,1'b0};

        // Reset state
        rst = 1'b1;
        ack = 1'b0;
        idle_tdr();
        step();
        step();
        rst = 1'b0;
        check("rst.select", 32'(msel), 32'd0);
        check("rst.hreq",   32'(hreq), 32'd0);
        check("rst.dout",   32'(dout), 32'd0);
        check("rst.so",     32'(so),   32'd0);
        check("rst.err",    32'(err),  32'd0);

        // Table-driven TDR vectors
        for (int i = 0; i < 15; i++) begin
            sel = tbl[i].sel;
            ce  = tbl[i].ce;
            se  = tbl[i].se;
            ue  = tbl[i].ue;
            si  = tbl[i].si;
            step();
            check($sformatf("vec%0d.so",     i), 32'(so),   32'(tbl[i].exp_so));
            check($sformatf("vec%0d.dout",   i), 32'(dout), 32'(tbl[i].exp_dout));
            check($sformatf("vec%0d.select", i), 32'(msel), 32'(tbl[i].exp_msel));
            check($sformatf("vec%0d.hreq",   i), 32'(hreq), 32'(tbl[i].exp_hreq));
        end
        idle_tdr();

        // Entry into TEST with ack already high
        ack = 1'b1;
        load(5'b01101);
        check("entry.k0.hreq", 32'(hreq), 32'd0);
        check("entry.dout",    32'(dout), 32'd5);
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("entry.k%0d.select", n), 32'(msel), 32'(n >= 6));
            check($sformatf("entry.k%0d.hreq",   n), 32'(hreq), 32'd1);
        end
        capture();
        shift_word(5'b10101, got);
        check("entry.capture", 32'(got), 32'h0D);

        // Exit from TEST, with a new request issued during SETTLE_OUT
        update();
        check("exit.k0.select", 32'(msel), 32'd1);
        for (int n = 1; n <= 11; n++) begin
            if (n == 1) begin
                sel = 1'b1;
                se  = 1'b1;
                si  = 1'b0;
            end else if (n == 2) begin
                sel = 1'b1;
                ue  = 1'b1;
            end
            step();
            idle_tdr();
            check($sformatf("exit.k%0d.select", n), 32'(msel), 32'(n == 11));
            check($sformatf("exit.k%0d.hreq",   n), 32'(hreq), 32'(n != 5));
            check($sformatf("exit.k%0d.dout",   n), 32'(dout), (n >= 2) ? 32'd2 : 32'd5);
        end

        // Ack drops in TEST: the error is set and TEST is kept.
        // A clear issued in the same cycle as a set loses.
        ack = 1'b0;
        step();
        check("tdrop.err",    32'(err),  32'd1);
        check("tdrop.select", 32'(msel), 32'd1);
        load(5'b10000);
        check("tdrop.setwins", 32'(err), 32'd1);
        for (int n = 0; n < 6; n++) step();
        check("tdrop.func.select", 32'(msel), 32'd0);
        check("tdrop.func.hreq",   32'(hreq), 32'd0);
        load(5'b10000);
        check("tdrop.clear", 32'(err), 32'd0);

        // Hold timeout with ack never asserted
        load(5'b01111);
        check("tmo.k0.hreq", 32'(hreq), 32'd0);
        for (int n = 1; n <= 66; n++) begin
            step();
            check($sformatf("tmo.k%0d.select", n), 32'(msel), 32'd0);
            check($sformatf("tmo.k%0d.hreq",   n), 32'(hreq), 32'(n != 65));
            check($sformatf("tmo.k%0d.err",    n), 32'(err),  32'(n >= 65));
        end
        capture();
        shift_word(5'b00111, got);
        check("tmo.capture", 32'(got), 32'h17);
        update();
        step();
        step();
        check("tmo.release.hreq", 32'(hreq), 32'd0);
        check("tmo.release.err",  32'(err),  32'd1);

        // Ack drops during the second SETTLE_IN cycle
        load(5'b10111);
        check("sdrop.preclear", 32'(err), 32'd0);
        ack = 1'b1;
        load(5'b01011);
        step();
        check("sdrop.k1.hreq", 32'(hreq), 32'd1);
        step();
        check("sdrop.k2.select", 32'(msel), 32'd0);
        step();
        check("sdrop.k3.select", 32'(msel), 32'd0);
        ack = 1'b0;
        step();
        check("sdrop.k4.select", 32'(msel), 32'd0);
        check("sdrop.k4.hreq",   32'(hreq), 32'd0);
        check("sdrop.k4.err",    32'(err),  32'd1);
        load(5'b10011);
        check("sdrop.clear", 32'(err), 32'd0);
        step();
        check("sdrop.func.hreq", 32'(hreq), 32'd0);

        // Reset asserted while in TEST
        ack = 1'b1;
        load(5'b01110);
        for (int n = 0; n < 7; n++) step();
        check("rtest.pre.select", 32'(msel), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rtest.select", 32'(msel), 32'd0);
        check("rtest.hreq",   32'(hreq), 32'd0);
        check("rtest.dout",   32'(dout), 32'd0);
        capture();
        shift_word(5'b00000, got);
        check("rtest.capture", 32'(got), 32'd0);
        step();
        check("rtest.after.hreq", 32'(hreq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
# firebird7_in_gate1_tessent_data_mux_ctrl

IJTAG-accessible controller that sequences the `ijtag_select` input of a data mux, which steers a WIDTH-bit datapath between functional data and IJTAG data. A host shifts a small test data register (TDR) to request test ownership and to load the test data word. The block then performs a hold-request/acknowledge handshake with the functional logic and applies settle delays before and after switching the mux. The block sits beside the mux on the gate1 IJTAG network and drives both `ijtag_select` and `ijtag_data_in` of the mux.

## Interface
Parameters:
- `WIDTH`, 3: mux data width.
- `SETTLE`, 4: settle cycles applied before entering and after leaving test ownership; legal range 1..255.
- `TIMEOUT`, 64: maximum cycles to wait for `func_hold_ack`; legal range 1..65535.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `ijtag_tck`, in, 1: sole clock; all state changes on its rising edge.
- `ijtag_reset`, in, 1: synchronous, active-high reset.
- `ijtag_sel`, in, 1: TDR selected on the IJTAG network.
- `ijtag_ce`, in, 1: capture enable.
- `ijtag_se`, in, 1: shift enable.
- `ijtag_ue`, in, 1: update enable.
- `ijtag_si`, in, 1: scan in.
- `ijtag_so`, out, 1: scan out; equals `sr[0]`.
- `func_hold_ack`, in, 1: functional side reports it is quiescent.
- `func_hold_req`, out, 1: request for the functional side to quiesce.
- `ijtag_select`, out, 1: drives the mux select.
- `ijtag_data_out`, out, WIDTH: drives the mux `ijtag_data_in`.
- `hold_error`, out, 1: sticky handshake error flag.

## Operation
TDR:
- Shift register `sr` is WIDTH+2 bits.
- Capture (`sel & ce`): `sr <= {hold_error, state==TEST, upd_data}`.
- Shift (`sel & se`): `sr <= {ijtag_si, sr[WIDTH+1:1]}`.
- Update (`sel & ue`): `upd_req <= sr[WIDTH]`, `upd_data <= sr[WIDTH-1:0]`. If `sr[WIDTH+1]` is 1, clear `hold_error`.
- Priority when enables coincide: capture, then shift, then update. No operation occurs without `ijtag_sel`.
- `ijtag_data_out = upd_data` at all times. The mux ignores it while select is 0.

FSM (Moore; outputs decode from the state register):
- FUNC: select=0, hold_req=0.
  - `upd_req` -> HOLD, timeout counter loaded with TIMEOUT-1.
- HOLD: hold_req=1.
  - `!upd_req` -> FUNC.
  - Otherwise, `func_hold_ack` -> SETTLE_IN, counter loaded with SETTLE-1.
  - Otherwise, counter==0 -> FUNC and set `hold_error`.
  - Otherwise, decrement the counter.
- SETTLE_IN: hold_req=1, select=0.
  - `!func_hold_ack` -> FUNC and set `hold_error`.
  - Otherwise, counter==0 -> TEST.
  - Otherwise, decrement the counter.
- TEST: hold_req=1, select=1.
  - `!upd_req` -> SETTLE_OUT, counter loaded with SETTLE-1.
  - A drop of `func_hold_ack` in TEST sets `hold_error` but does not leave TEST.
- SETTLE_OUT: hold_req=1, select=0.
  - counter==0 -> FUNC.
  - Otherwise, decrement the counter.
  - `upd_req` is ignored until FUNC is reached.
- Counter width: `$clog2(max(SETTLE,TIMEOUT))`. Counters never wrap; they only decrement from a loaded value to 0.
- Error set and clear in the same cycle: set wins.

## Timing
- Reset values:
  - state=FUNC, `sr`=0, `upd_req`=0, `upd_data`=0, `hold_error`=0.
  - Hence `ijtag_select`=0, `func_hold_req`=0, `ijtag_data_out`=0, `ijtag_so`=0.
- Reset mid-sequence, from any state: select and hold_req are both 0 on the cycle after the reset edge. No settle is applied.
- Entry latency, with the update at edge k:
  - `upd_req` is high after edge k.
  - HOLD, and therefore `func_hold_req`, is high after edge k+1.
  - If `func_hold_ack` is already high at edge k+2, SETTLE_IN follows.
  - `ijtag_select` rises after edge k+2+SETTLE.
- Exit latency, with the clearing update at edge k:
  - SETTLE_OUT after edge k+1, so `ijtag_select` falls after edge k+1.
  - `func_hold_req` falls after edge k+1+SETTLE.
- `ijtag_select` is never 1 unless `func_hold_req` has been 1 for at least SETTLE+1 cycles.
- `ijtag_data_out` changes only on update edges. New data during TEST reaches the mux one cycle after the update edge.

## Test plan
- Reset, then shift 5'b0_1_101 with `func_hold_ack` tied 1 and SETTLE=4 -> `func_hold_req` high 1 cycle after the update; `ijtag_select` high 6 cycles after the update; `ijtag_data_out`=3'b101.
- Ack never asserted, TIMEOUT=64 -> HOLD for 64 cycles, then FUNC; `hold_error`=1; `ijtag_select` stays 0 throughout. A capture then shifts out `sr[WIDTH+1]`=1.
- From TEST, update with req=0 -> `ijtag_select` falls 1 cycle after the update; `func_hold_req` falls 4 cycles later. A new req update during SETTLE_OUT is honored only after FUNC is reached.
- Ack drops on the 2nd SETTLE_IN cycle -> FUNC next cycle; `hold_error`=1; select never rises. An update with `sr[WIDTH+1]`=1 clears the flag.
- Assert `ijtag_reset` in TEST -> the next cycle shows `ijtag_select`=0, `func_hold_req`=0, `ijtag_data_out`=0, and a capture returns all zeros.
- Assert ce, se and ue together with `ijtag_sel`=1 -> only the capture takes effect. With `ijtag_sel`=0 -> `sr` and the update register are unchanged.
